// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//
// Issue / write-back controller for a combinational ALU. It accepts one
// register-register instruction through a valid/ready handshake and reads the
// operands from an internal 4 x W register file. It drives the ALU inputs from
// registers, then captures the ALU result and flags one cycle later and writes
// the result back. Each instruction takes three cycles: IDLE -> ISSUE -> WB.
//
// Optional feature macro: ALU_IMM_EN
//   defined     : when IInstr[0] = 1 at the handshake, ORb takes IImm
//   not defined : IInstr[0] and IImm are ignored, ORb is always R[rb]
//
// Ports
//   ICLK, IRSTn      clock, asynchronous active-low reset
//   IInstValid       instruction present
//   OInstReady       controller idle, can accept an instruction
//   IInstr[10:0]     [10:7] opcode, [6:5] rd, [4:3] ra, [2:1] rb, [0] imm select
//   IImm[W-1:0]      immediate operand
//   IWrEn/IWrAddr/IWrData  external register load, honoured only in IDLE
//   ORa, ORb, OOPALU ALU operand and opcode drives
//   IALUD, IFgn, IFgz ALU result and flags
//   OWbValid         one-cycle write-back strobe
//   OWbReg, OWbData  register and value of the last write-back
//   OFlagN, OFlagZ   flags latched from the last non-NOP instruction
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_exec_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 8
) (
    input  logic         ICLK,
    input  logic         IRSTn,
    input  logic         IInstValid,
    output logic         OInstReady,
    input  logic [10:0]  IInstr,
    input  logic [W-1:0] IImm,
    input  logic         IWrEn,
    input  logic [1:0]   IWrAddr,
    input  logic [W-1:0] IWrData,
    output logic [W-1:0] ORa,
    output logic [W-1:0] ORb,
    output logic [3:0]   OOPALU,
    input  logic [W-1:0] IALUD,
    input  logic         IFgn,
    input  logic         IFgz,
    output logic         OWbValid,
    output logic [1:0]   OWbReg,
    output logic [W-1:0] OWbData,
    output logic         OFlagN,
    output logic         OFlagZ
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;

    logic [1:0]   r_state;
    logic [W-1:0] r_regs [NREG];
    logic [1:0]   r_rd;
    logic [W-1:0] r_ra;
    logic [W-1:0] r_rb;
    logic [3:0]   r_op;
    logic         r_wb_valid;
    logic [1:0]   r_wb_reg;
    logic [W-1:0] r_wb_data;
    logic         r_flag_n;
    logic         r_flag_z;

    logic [3:0]   w_opcode;
    logic [1:0]   w_rd;
    logic [1:0]   w_ra;
    logic [1:0]   w_rb;
    logic         w_imm_sel;
    logic [W-1:0] w_opb;
    logic         w_handshake;
    logic         w_ext_wr;
    logic         w_alu_wr;

    assign w_opcode  = IInstr[10:7];
    assign w_rd      = IInstr[6:5];
    assign w_ra      = IInstr[4:3];
    assign w_rb      = IInstr[2:1];
    assign w_imm_sel = IInstr[0];

`ifdef ALU_IMM_EN
    assign w_opb = w_imm_sel ? IImm : r_regs[w_rb];
`else
    assign w_opb = r_regs[w_rb];
    // Immediate path is compiled out; sink the inputs so they stay visible.
    logic w_unused;
    assign w_unused = ^{IImm, w_imm_sel};
`endif

    assign w_handshake = IInstValid & (r_state == S_IDLE);
    assign w_ext_wr    = IWrEn & (r_state == S_IDLE);
    // OOPALU still holds the opcode of the instruction in flight during ISSUE.
    assign w_alu_wr    = (r_state == S_ISSUE) && (r_op != 4'h0);

    // Register file. ALU write-back and external load can never coincide
    // (different states). Operand reads above use pre-edge values, so a load
    // in the handshake cycle is seen by the next instruction, not this one.
    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_alu_wr && (r_rd == 2'(i))) begin
                    r_regs[i] <= IALUD;
                end else if (w_ext_wr && (IWrAddr == 2'(i))) begin
                    r_regs[i] <= IWrData;
                end
            end
        end
    end

    // Control FSM, operand registers and write-back capture.
    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_op       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
            r_flag_n   <= 1'b0;
            r_flag_z   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_ra    <= r_regs[w_ra];
                        r_rb    <= w_opb;
                        r_op    <= w_opcode;
                        r_rd    <= w_rd;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_alu_wr) begin
                        r_wb_data  <= IALUD;
                        r_wb_reg   <= r_rd;
                        r_flag_n   <= IFgn;
                        r_flag_z   <= IFgz;
                        r_wb_valid <= 1'b1;
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign OInstReady = (r_state == S_IDLE);
    assign ORa        = r_ra;
    assign ORb        = r_rb;
    assign OOPALU     = r_op;
    assign OWbValid   = r_wb_valid;
    assign OWbReg     = r_wb_reg;
    assign OWbData    = r_wb_data;
    assign OFlagN     = r_flag_n;
    assign OFlagZ     = r_flag_z;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
`timescale 1ns/1ps

module tb_alu_exec_ctrl;

    logic        ICLK;
    logic        IRSTn;
    logic        IInstValid;
    logic        OInstReady;
    logic [10:0] IInstr;
    logic [7:0]  IImm;
    logic        IWrEn;
    logic [1:0]  IWrAddr;
    logic [7:0]  IWrData;
    logic [7:0]  ORa;
    logic [7:0]  ORb;
    logic [3:0]  OOPALU;
    logic [7:0]  IALUD;
    logic        IFgn;
    logic        IFgz;
    logic        OWbValid;
    logic [1:0]  OWbReg;
    logic [7:0]  OWbData;
    logic        OFlagN;
    logic        OFlagZ;

    int n_checks = 0;
    int n_pass   = 0;
    int hs1;
    int hs2;

    alu_exec_ctrl #(.NREG(4), .W(8)) dut (
        .ICLK       (ICLK),
        .IRSTn      (IRSTn),
        .IInstValid (IInstValid),
        .OInstReady (OInstReady),
        .IInstr     (IInstr),
        .IImm       (IImm),
        .IWrEn      (IWrEn),
        .IWrAddr    (IWrAddr),
        .IWrData    (IWrData),
        .ORa        (ORa),
        .ORb        (ORb),
        .OOPALU     (OOPALU),
        .IALUD      (IALUD),
        .IFgn       (IFgn),
        .IFgz       (IFgz),
        .OWbValid   (OWbValid),
        .OWbReg     (OWbReg),
        .OWbData    (OWbData),
        .OFlagN     (OFlagN),
        .OFlagZ     (OFlagZ)
    );

    initial begin
        ICLK = 1'b0;
        forever #5 ICLK = ~ICLK;
    end

    // ALU stub: opcode 1 = add, anything else = ~(a+b) so a stray NOP write is visible.
    always_comb begin
        IALUD = (OOPALU == 4'h1) ? (ORa + ORb) : ~(ORa + ORb);
        IFgz  = (IALUD == 8'h00);
        IFgn  = IALUD[7];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        @(negedge ICLK);
        IWrEn = 1'b1; IWrAddr = addr; IWrData = data;
        @(negedge ICLK);
        IWrEn = 1'b0;
        $display("load R%0d <= %02h", addr, data);
    endtask

    // One full instruction from IDLE; optional external write in the handshake cycle.
    task automatic issue_chk(
        input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
        input logic isel, input logic [7:0] imm,
        input logic we, input logic [1:0] wa, input logic [7:0] wd,
        input logic [7:0] ea, input logic [7:0] eb, input logic ewb,
        input logic [1:0] erd, input logic [7:0] ed, input logic en, input logic ez);
        @(negedge ICLK);
        check("ready_pre", OInstReady, 1'b1);
        IInstValid = 1'b1; IInstr = {op, rd, ra, rb, isel}; IImm = imm;
        IWrEn = we; IWrAddr = wa; IWrData = wd;
        @(negedge ICLK);
        IInstValid = 1'b0; IWrEn = 1'b0;
        check("ora", ORa, ea);
        check("orb", ORb, eb);
        check("opalu", OOPALU, op);
        check("ready_issue", OInstReady, 1'b0);
        check("wbv_issue", OWbValid, 1'b0);
        @(negedge ICLK);
        check("ready_wb", OInstReady, 1'b0);
        check("wbv_wb", OWbValid, ewb);
        check("wbreg", OWbReg, erd);
        check("wbdata", OWbData, ed);
        check("flagn", OFlagN, en);
        check("flagz", OFlagZ, ez);
        @(negedge ICLK);
        check("ready_idle", OInstReady, 1'b1);
        check("wbv_idle", OWbValid, 1'b0);
        $display("txn op=%0h rd=%0d ra=%0d rb=%0d -> a=%02h b=%02h wb=%0b data=%02h N=%0b Z=%0b",
                 op, rd, ra, rb, ORa, ORb, ewb, OWbData, OFlagN, OFlagZ);
    endtask

    initial begin
        IRSTn = 1'b0; IInstValid = 1'b0; IInstr = '0; IImm = '0;
        IWrEn = 1'b0; IWrAddr = '0; IWrData = '0;
        repeat (3) @(negedge ICLK);
        IRSTn = 1'b1;
        @(negedge ICLK);
        check("rst_ready", OInstReady, 1'b1);
        check("rst_wbv", OWbValid, 1'b0);
        check("rst_ora", ORa, 8'h00);
        check("rst_orb", ORb, 8'h00);
        check("rst_op", OOPALU, 4'h0);
        check("rst_wbreg", OWbReg, 2'd0);
        check("rst_wbdata", OWbData, 8'h00);
        check("rst_flags", {OFlagN, OFlagZ}, 2'b00);
        $display("reset released");

        // 0 + 0 -> R3 = 0, Z = 1
        issue_chk(4'h1, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h00, 8'h00, 1'b1, 2'd3, 8'h00, 1'b0, 1'b1);

        load(2'd0, 8'h02);
        load(2'd1, 8'h02);
        // 2 + 2 -> R2 = 4
        issue_chk(4'h1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h02, 8'h02, 1'b1, 2'd2, 8'h04, 1'b0, 1'b0);

        // Back-to-back with IInstValid held: R3 = R2+R2 = 8, then R0 = R2+R3 = 12
        hs1 = -1; hs2 = -1;
        @(negedge ICLK);
        IInstValid = 1'b1; IInstr = {4'h1, 2'd3, 2'd2, 2'd2, 1'b0};
        for (int c = 0; c < 20 && hs2 < 0; c++) begin
            if (OInstReady) begin
                if (hs1 < 0) hs1 = c;
                else         hs2 = c;
            end
            @(negedge ICLK);
            if (hs1 == c) begin
                check("bb_ora1", ORa, 8'h04);
                IInstr = {4'h1, 2'd0, 2'd2, 2'd3, 1'b0};
            end
        end
        IInstValid = 1'b0;
        check("bb_gap", hs2 - hs1, 3);
        check("bb_ora2", ORa, 8'h04);
        check("bb_orb2", ORb, 8'h08);
        @(negedge ICLK);
        check("bb_wbv", OWbValid, 1'b1);
        check("bb_wbreg", OWbReg, 2'd0);
        check("bb_wbdata", OWbData, 8'h0C);
        @(negedge ICLK);
        $display("txn back-to-back gap=%0d data=%02h", hs2 - hs1, OWbData);

        // IWrEn to R3 during ISSUE must be ignored; R1 = 2+2 = 4
        @(negedge ICLK);
        IInstValid = 1'b1; IInstr = {4'h1, 2'd1, 2'd1, 2'd1, 1'b0};
        @(negedge ICLK);
        IInstValid = 1'b0;
        IWrEn = 1'b1; IWrAddr = 2'd3; IWrData = 8'h55;
        @(negedge ICLK);
        IWrEn = 1'b0;
        check("issue_wr_wbdata", OWbData, 8'h04);
        @(negedge ICLK);
        $display("txn IWrEn during ISSUE, wb data=%02h", OWbData);
        // R3 still 8: R2 = 8+8 = 0x10
        issue_chk(4'h1, 2'd2, 2'd3, 2'd3, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h08, 8'h08, 1'b1, 2'd2, 8'h10, 1'b0, 1'b0);

        load(2'd1, 8'h80);
        // R3 = 0x80 + 0x0C = 0x8C, N = 1
        issue_chk(4'h1, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h80, 8'h0C, 1'b1, 2'd3, 8'h8C, 1'b1, 1'b0);
        // NOP targeting R2: nothing changes
        issue_chk(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h0C, 8'h80, 1'b0, 2'd3, 8'h8C, 1'b1, 1'b0);
        // R2 still 0x10: R2 = 0x8C + 0x10 = 0x9C
        issue_chk(4'h1, 2'd2, 2'd3, 2'd2, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h8C, 8'h10, 1'b1, 2'd2, 8'h9C, 1'b1, 1'b0);

        // Handshake with R0 <= 1 in the same cycle: operands use old R0 = 0x0C
        issue_chk(4'h1, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 2'd0, 8'h01,
                  8'h0C, 8'h0C, 1'b1, 2'd1, 8'h18, 1'b0, 1'b0);
        issue_chk(4'h1, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h01, 8'h18, 1'b1, 2'd3, 8'h19, 1'b0, 1'b0);

        // Reset during ISSUE
        @(negedge ICLK);
        IInstValid = 1'b1; IInstr = {4'h1, 2'd2, 2'd0, 2'd0, 1'b0};
        @(negedge ICLK);
        IInstValid = 1'b0;
        IRSTn = 1'b0;
        #1;
        check("midrst_ready", OInstReady, 1'b1);
        check("midrst_wbv", OWbValid, 1'b0);
        check("midrst_wbdata", OWbData, 8'h00);
        check("midrst_ora", ORa, 8'h00);
        @(negedge ICLK);
        IRSTn = 1'b1;
        @(negedge ICLK);
        check("midrst_wbv2", OWbValid, 1'b0);
        check("midrst_ready2", OInstReady, 1'b1);
        $display("txn reset during ISSUE");
        issue_chk(4'h1, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h00, 8'h00, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1);
        issue_chk(4'h1, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00,
                  8'h00, 8'h00, 1'b1, 2'd1, 8'h00, 1'b0, 1'b1);

        // Immediate select
        load(2'd0, 8'h02);
        load(2'd2, 8'h05);
`ifdef ALU_IMM_EN
        issue_chk(4'h1, 2'd1, 2'd0, 2'd2, 1'b1, 8'h80, 1'b0, 2'd0, 8'h00,
                  8'h02, 8'h80, 1'b1, 2'd1, 8'h82, 1'b1, 1'b0);
`else
        issue_chk(4'h1, 2'd1, 2'd0, 2'd2, 1'b1, 8'h80, 1'b0, 2'd0, 8'h00,
                  8'h02, 8'h05, 1'b1, 2'd1, 8'h07, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
